// File: rtl/sqrt2_host_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sqrt2_host_pkg                                         |
// | Description : Shared types and constants for the sqrt2 host          |
// |               controller (FSM states, quiet-NaN pattern, sample      |
// |               threshold).                                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package sqrt2_host_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } host_state_t;

  // Response pattern reported when the core never answers
  localparam logic [15:0] QNAN = 16'hFE00;

  // The core only drives the bus from its second enabled edge onwards
  localparam logic [5:0] MIN_SAMPLE_ELAPSED = 6'd2;

  // Saturation value of the 6-bit elapsed counter
  localparam logic [5:0] ELAPSED_MAX = 6'h3F;

endpackage
`default_nettype wire

// File: rtl/sqrt2_host_iobuf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sqrt2_host_iobuf                                       |
// | Description : 16-bit tri-state pad driver for the shared core bus.   |
// |               Drives IO with D_OUT when OE is high, otherwise         |
// |               releases it; D_IN always mirrors the bus.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sqrt2_host_iobuf (
  input  logic        OE,
  input  logic [15:0] D_OUT,
  output logic [15:0] D_IN,
  inout  wire  [15:0] IO
);

  // Drive the bus only while output-enabled; high-Z otherwise
  assign IO   = OE ? D_OUT : 16'hzzzz;

  // Receive path is always live
  assign D_IN = IO;

endmodule
`default_nettype wire

// File: rtl/sqrt2_host.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sqrt2_host                                             |
// | Description : Host-side controller for the sqrt2 fp16 square-root    |
// |               core. Accepts an operand on a valid/ready channel,     |
// |               loads it over the shared bus, waits for RESULT (or a   |
// |               timeout) and returns data plus status flags.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sqrt2_host
  import sqrt2_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [15:0] REQ_DATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [15:0] RSP_DATA,
  output logic        RSP_NAN,
  output logic        RSP_PINF,
  output logic        RSP_NINF,
  output logic        RSP_TIMEOUT,
  inout  wire  [15:0] IO_DATA,
  output logic        ENABLE,
  input  logic        IS_NAN,
  input  logic        IS_PINF,
  input  logic        IS_NINF,
  input  logic        RESULT
);

  localparam logic [5:0] c_timeout = 6'(TIMEOUT_CYCLES);

  host_state_t r_state;
  logic [15:0] r_opnd;
  logic [5:0]  r_elapsed;
  logic        r_oe;
  logic        r_enable;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_data;
  logic        r_rsp_nan;
  logic        r_rsp_pinf;
  logic        r_rsp_ninf;
  logic        r_rsp_timeout;

  logic [15:0] w_bus_in;
  logic        w_sample;
  logic        w_timeout;

  // Bus direction control lives in the pad driver, the FSM only owns OE
  sqrt2_host_iobuf u_iobuf (
    .OE    (r_oe),
    .D_OUT (r_opnd),
    .D_IN  (w_bus_in),
    .IO    (IO_DATA)
  );

  // Early RESULT on special inputs is ignored until the core owns the bus
  assign w_sample  = RESULT && (r_elapsed >= MIN_SAMPLE_ELAPSED);
  assign w_timeout = (r_elapsed == c_timeout);

  // Host FSM with elapsed counter and registered response/bus-control outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= ST_IDLE;
      r_opnd        <= 16'h0000;
      r_elapsed     <= 6'd0;
      r_oe          <= 1'b0;
      r_enable      <= 1'b0;
      r_req_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= 16'h0000;
      r_rsp_nan     <= 1'b0;
      r_rsp_pinf    <= 1'b0;
      r_rsp_ninf    <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (REQ_VALID) begin
            r_opnd      <= REQ_DATA;
            r_enable    <= 1'b1;
            r_oe        <= 1'b1;
            r_req_ready <= 1'b0;
            r_state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_elapsed <= 6'd1;
          r_oe      <= 1'b0;
          r_state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_elapsed != ELAPSED_MAX) begin
            r_elapsed <= r_elapsed + 6'd1;
          end
          if (w_sample) begin
            r_rsp_data    <= w_bus_in;
            r_rsp_nan     <= IS_NAN;
            r_rsp_pinf    <= IS_PINF;
            r_rsp_ninf    <= IS_NINF;
            r_rsp_timeout <= 1'b0;
            r_enable      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= ST_RESP;
          end else if (w_timeout) begin
            r_rsp_data    <= QNAN;
            r_rsp_nan     <= 1'b1;
            r_rsp_pinf    <= 1'b0;
            r_rsp_ninf    <= 1'b0;
            r_rsp_timeout <= 1'b1;
            r_enable      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (RSP_READY) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Ready is forced low for the whole time reset is asserted
  assign REQ_READY   = r_req_ready & RST_N;
  assign ENABLE      = r_enable;
  assign RSP_VALID   = r_rsp_valid;
  assign RSP_DATA    = r_rsp_data;
  assign RSP_NAN     = r_rsp_nan;
  assign RSP_PINF    = r_rsp_pinf;
  assign RSP_NINF    = r_rsp_ninf;
  assign RSP_TIMEOUT = r_rsp_timeout;

endmodule
`default_nettype wire

// File: doc/sqrt2_host.md
# sqrt2_host

Host-side controller for the `sqrt2` half-precision square-root core. It accepts operands on a valid/ready request channel and runs the core's bus protocol: it drives `ENABLE`, drives `IO_DATA` during the load cycle, then releases the bus and waits for `RESULT`. It then samples `IO_DATA` and the status flags, drops `ENABLE` to reset the core, and returns the result on a valid/ready response channel. It sits between the core and any requester (test harness or datapath) and is the only device driving the core's `ENABLE` and operand.

## Interface
- `TIMEOUT_CYCLES`, default 32: number of `ENABLE`-high edges allowed before the operation is abandoned. Legal range 16..63.
- `CLK`, input, 1: single clock, rising edge.
- `RST_N`, input, 1: asynchronous, active-low reset.
- `REQ_VALID`, input, 1: operand available.
- `REQ_READY`, output, 1: host idle; accepts the operand.
- `REQ_DATA`, input, 16: fp16 operand.
- `RSP_VALID`, output, 1: result held.
- `RSP_READY`, input, 1: consumer takes the result.
- `RSP_DATA`, output, 16: fp16 result.
- `RSP_NAN`, `RSP_PINF`, `RSP_NINF`, `RSP_TIMEOUT`, output, 1 each: captured status.
- `IO_DATA`, inout, 16: shared bus to the core.
- `ENABLE`, output, 1: core enable. While low, the core is held in reset.
- `IS_NAN`, `IS_PINF`, `IS_NINF`, `RESULT`, input, 1 each: core status.

## Operation
- FSM states: IDLE → LOAD → WAIT → RESP → IDLE.
- **IDLE**
  - `REQ_READY`=1, `ENABLE`=0, bus released.
  - On `REQ_VALID`&&`REQ_READY`: latch `REQ_DATA` into `opnd` and go to LOAD.
- **LOAD** (exactly 1 cycle)
  - `ENABLE`=1 and `IO_DATA`=`opnd`. The core latches the operand at the closing edge.
  - Set `elapsed`=1 and go to WAIT.
- **WAIT**
  - `ENABLE`=1, `IO_DATA` high-Z. `elapsed` (6 bits, saturating) increments each edge.
  - Sample condition: `RESULT`=1 && `elapsed`>=2. The core drives the bus only from its second enabled edge on, and `RESULT` can rise earlier on special inputs.
  - On the sample condition: capture `IO_DATA`, `IS_NAN`, `IS_PINF` and `IS_NINF` into the `RSP_*` registers, clear `RSP_TIMEOUT`, and go to RESP.
  - Else, if `elapsed`==`TIMEOUT_CYCLES`: capture `RSP_DATA`=16'hFE00, `RSP_NAN`=1, `RSP_TIMEOUT`=1, other flags 0, and go to RESP.
  - The sample condition has priority when both hold in the same cycle.
- **RESP**
  - `ENABLE`=0, bus released, `RSP_VALID`=1. Response registers are stable.
  - On `RSP_READY`: go to IDLE.
- The host never drives `IO_DATA` outside LOAD.
- No new LOAD starts within 2 cycles of `ENABLE` falling, because RESP and IDLE each last at least 1 cycle. This guarantees the core has cleared and stopped driving.
- **Reset** (async, mid-operation included):
  - Immediately: state=IDLE, `ENABLE`=0, bus high-Z.
  - `REQ_READY`=0 while `RST_N` is low, and 1 after release.
  - `RSP_VALID`=0; `RSP_DATA`=0; all `RSP_*` flags 0.
  - `opnd`=0; `elapsed`=0.

## Timing
- Edge numbering: E0 = edge of the request handshake; E1 ends LOAD.
- Bus turnaround: the host releases at E1 and the core drives from E2. There is one cycle of guaranteed no-drive.
- Special-case inputs (`RESULT` high after E1): capture at E3, `RSP_VALID` high after E3.
- Core path (`RESULT` high after E14): capture at E15, `RSP_VALID` high after E15.
- Timeout: `RSP_VALID` high after E(`TIMEOUT_CYCLES`+1).
- Back-pressure: RESP holds indefinitely while `RSP_READY`=0. `ENABLE` stays 0 throughout.
- Throughput: at most one operation per (latency + 2) cycles. There is no overlap and no request queue.

## Structure
- Package `sqrt2_host_pkg`:
  - State enum `host_state_t`.
  - `QNAN` = 16'hFE00.
  - `MIN_SAMPLE_ELAPSED` = 2.
- One sub-module, `sqrt2_host_iobuf`: 16-bit tri-state driver (`OE`, `D_OUT`, `D_IN`, `IO`). It keeps bus direction control out of the FSM.
- All other logic (FSM, `elapsed` counter, response registers) lives in the top module.

## Test plan
All scenarios use a bench core model with programmable data, flags and `RESULT` timing, plus a bus-contention checker.

- **Core path:** REQ 0x4400, model drives 0x4000 with `RESULT` from E14 → `RSP_DATA`=0x4000, flags 0, `RSP_VALID` after E15. `IO_DATA` is driven by the host only in the LOAD cycle.
- **Negative input:** REQ 0xBC00, model sets `IS_NAN`=1, data 0xFE00, `RESULT` after E1 → capture at E3, `RSP_DATA`=0xFE00, `RSP_NAN`=1. No sample at E2, even though `RESULT`=1.
- **Infinity:** REQ 0x7C00, model sets `IS_PINF`=1, data 0x7C00 → `RSP_DATA`=0x7C00, `RSP_PINF`=1, `RSP_TIMEOUT`=0.
- **Timeout:** model never asserts `RESULT` → `RSP_DATA`=0xFE00, `RSP_TIMEOUT`=1, `RSP_VALID` after E33.
- **Back-pressure:** `RSP_READY` held low for 10 cycles, then a second REQ issued back-to-back → response stable throughout. `ENABLE` is low for at least 2 cycles between operations. The second result is correct.
- **Reset mid-operation:** `RST_N` pulsed low during WAIT → `ENABLE`=0 and bus high-Z with no clock edge. After release, `REQ_READY`=1, and the next operation completes normally.
